// File: rtl/execute_cycle_if.sv
// Decode/execute/memory boundary signals of the execute stage.
// The slave modport is the execute stage; the master modport is whatever drives it.
interface execute_cycle_if #(
  parameter int XLEN = 32
);
  logic            RegWriteE;
  logic            MemWriteE;
  logic            ResultSrcE;
  logic            ALUSrcE;
  logic            BranchE;
  logic            FlushE;
  logic [2:0]      ALUControlE;
  logic [XLEN-1:0] RD1_E;
  logic [XLEN-1:0] RD2_E;
  logic [XLEN-1:0] Imm_Ext_E;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCPlus4E;
  logic [4:0]      RD_E;
  logic [1:0]      ForwardA_E;
  logic [1:0]      ForwardB_E;
  logic [XLEN-1:0] ResultW;

  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic            StallE;
  logic            RegWriteM;
  logic            MemWriteM;
  logic            ResultSrcM;
  logic [4:0]      RD_M;
  logic [XLEN-1:0] PCPlus4M;
  logic [XLEN-1:0] WriteDataM;
  logic [XLEN-1:0] ALU_ResultM;

  modport master (
    output RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, FlushE, ALUControlE,
           RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E, ForwardA_E, ForwardB_E, ResultW,
    input  PCSrcE, PCTargetE, StallE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
           PCPlus4M, WriteDataM, ALU_ResultM
  );

  modport slave (
    input  RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, FlushE, ALUControlE,
           RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E, ForwardA_E, ForwardB_E, ResultW,
    output PCSrcE, PCTargetE, StallE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
           PCPlus4M, WriteDataM, ALU_ResultM
  );
endinterface

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, BEQ resolution and the EX/MEM register.
// Define EXEC_MUL_EN to add an iterative shift-add multiplier on ALUControlE=111.
//
// state | meaning (EXEC_MUL_EN only)
// IDLE  | normal single-cycle execution; a MUL here captures operands and stalls
// BUSY  | one shift-add step per cycle, stage stalled, bubbles sent downstream
// DONE  | product ready, written to EX/MEM with the held E-stage controls
module execute_cycle #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input logic            clk,
  input logic            rst,
  execute_cycle_if.slave ex
);
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_SLTU = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  if (XLEN != 32 || MUL_CYCLES < 1) begin : g_cfg_check
    $error("execute_cycle: only XLEN=32 and MUL_CYCLES>=1 are supported");
  end

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b_fwd;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] sub_res;
  logic [XLEN-1:0] mul_res;
  logic            zero;
  logic            stall;
  logic            load_bubble;

  always_comb begin
    unique case (ex.ForwardA_E)
      2'b01:   src_a = ex.ResultW;
      2'b10:   src_a = ex.ALU_ResultM;
      default: src_a = ex.RD1_E;
    endcase
    unique case (ex.ForwardB_E)
      2'b01:   src_b_fwd = ex.ResultW;
      2'b10:   src_b_fwd = ex.ALU_ResultM;
      default: src_b_fwd = ex.RD2_E;
    endcase
  end

  assign src_b   = ex.ALUSrcE ? ex.Imm_Ext_E : src_b_fwd;
  assign sub_res = src_a - src_b;
  assign zero    = (sub_res == '0);

  always_comb begin
    unique case (ex.ALUControlE)
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = sub_res;
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      OP_MUL:  alu_res = mul_res;
      default: alu_res = src_a + src_b;
    endcase
  end

`ifdef EXEC_MUL_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

  localparam int CNT_W = $clog2(MUL_CYCLES + 1);

  mul_state_t       state;
  mul_state_t       state_nxt;
  logic [CNT_W-1:0] step_cnt;
  logic [XLEN-1:0]  mul_acc;
  logic [XLEN-1:0]  mul_mcand;
  logic [XLEN-1:0]  mul_mplier;
  logic             mul_start;
  logic             mul_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    unique case (state)
      IDLE: begin
        if (ex.ALUControlE == OP_MUL && !ex.FlushE) begin
          state_nxt = BUSY;
          stall     = 1'b1;
          mul_start = 1'b1;
        end
      end
      BUSY: begin
        stall    = 1'b1;
        mul_step = 1'b1;
        if (ex.FlushE)                               state_nxt = IDLE;
        else if (step_cnt == CNT_W'(MUL_CYCLES - 1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Only the low XLEN product bits are kept, so the multiplicand may shift out freely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      step_cnt   <= '0;
    end else if (mul_start) begin
      mul_acc    <= '0;
      mul_mcand  <= src_a;
      mul_mplier <= src_b;
      step_cnt   <= '0;
    end else if (mul_step) begin
      if (mul_mplier[0]) mul_acc <= mul_acc + mul_mcand;
      mul_mcand  <= mul_mcand << 1;
      mul_mplier <= mul_mplier >> 1;
      step_cnt   <= step_cnt + CNT_W'(1);
    end
  end

  assign mul_res = mul_acc;
`else
  assign stall   = 1'b0;
  assign mul_res = src_a + src_b;
`endif

  assign ex.StallE    = stall & ~rst;
  assign ex.PCSrcE    = ex.BranchE & zero & ~ex.FlushE & ~ex.StallE;
  assign ex.PCTargetE = ex.PCE + ex.Imm_Ext_E;
  assign load_bubble  = ex.FlushE | stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex.RegWriteM   <= 1'b0;
      ex.MemWriteM   <= 1'b0;
      ex.ResultSrcM  <= 1'b0;
      ex.RD_M        <= '0;
      ex.PCPlus4M    <= '0;
      ex.WriteDataM  <= '0;
      ex.ALU_ResultM <= '0;
    end else if (load_bubble) begin
      ex.RegWriteM   <= 1'b0;
      ex.MemWriteM   <= 1'b0;
      ex.ResultSrcM  <= 1'b0;
      ex.RD_M        <= '0;
      ex.PCPlus4M    <= '0;
      ex.WriteDataM  <= '0;
      ex.ALU_ResultM <= '0;
    end else begin
      ex.RegWriteM   <= ex.RegWriteE;
      ex.MemWriteM   <= ex.MemWriteE;
      ex.ResultSrcM  <= ex.ResultSrcE;
      ex.RD_M        <= ex.RD_E;
      ex.PCPlus4M    <= ex.PCPlus4E;
      ex.WriteDataM  <= src_b_fwd;
      ex.ALU_ResultM <= alu_res;
    end
  end
endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: directed cases plus randomized instructions
// checked against a behavioural model of the stage (EXEC_MUL_EN adds multiplier cases).
module tb_execute_cycle;
  localparam int MUL_CYCLES = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [31:0] m_alu;  // model's view of the registered ALU result, used for forwarding

  execute_cycle_if ifc ();

  execute_cycle #(.XLEN(32), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .ex  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fwd_sel(input logic [1:0] sel, input logic [31:0] rd,
                                          input logic [31:0] res_w);
    if (sel == 2'b01) return res_w;
    if (sel == 2'b10) return m_alu;
    return rd;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return (a < b) ? 32'd1 : 32'd0;
`ifdef EXEC_MUL_EN
      default: return a * b;
`else
      default: return a + b;
`endif
    endcase
  endfunction

  task automatic drive(input logic rw, input logic mw, input logic rs, input logic asrc,
                       input logic br, input logic fl, input logic [2:0] op,
                       input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [31:0] res_w, input logic [4:0] rd,
                       input logic [1:0] fa, input logic [1:0] fb);
    @(negedge clk);
    ifc.RegWriteE   = rw;
    ifc.MemWriteE   = mw;
    ifc.ResultSrcE  = rs;
    ifc.ALUSrcE     = asrc;
    ifc.BranchE     = br;
    ifc.FlushE      = fl;
    ifc.ALUControlE = op;
    ifc.RD1_E       = rd1;
    ifc.RD2_E       = rd2;
    ifc.Imm_Ext_E   = imm;
    ifc.PCE         = pc;
    ifc.PCPlus4E    = pc + 32'd4;
    ifc.ResultW     = res_w;
    ifc.RD_E        = rd;
    ifc.ForwardA_E  = fa;
    ifc.ForwardB_E  = fb;
  endtask

  // Checks the combinational outputs for the instruction now in E, clocks it, then
  // checks the EX/MEM contents the model predicts.
  task automatic run_cycle(input string tag);
    logic [31:0] a, bf, b, res;
    logic        taken;
    #1;
    a     = fwd_sel(ifc.ForwardA_E, ifc.RD1_E, ifc.ResultW);
    bf    = fwd_sel(ifc.ForwardB_E, ifc.RD2_E, ifc.ResultW);
    b     = ifc.ALUSrcE ? ifc.Imm_Ext_E : bf;
    res   = ref_alu(ifc.ALUControlE, a, b);
    taken = ifc.BranchE && (res == 32'd0) && !ifc.FlushE;
    check_val({tag, "_stall"}, {31'd0, ifc.StallE}, 32'd0);
    check_val({tag, "_pcsrc"}, {31'd0, ifc.PCSrcE}, {31'd0, taken});
    check_val({tag, "_target"}, ifc.PCTargetE, ifc.PCE + ifc.Imm_Ext_E);
    @(posedge clk);
    #1;
    if (ifc.FlushE) begin
      check_val({tag, "_m_ctl"}, {29'd0, ifc.RegWriteM, ifc.MemWriteM, ifc.ResultSrcM}, 32'd0);
      check_val({tag, "_m_rd"}, {27'd0, ifc.RD_M}, 32'd0);
      check_val({tag, "_m_alu"}, ifc.ALU_ResultM, 32'd0);
      m_alu = 32'd0;
    end else begin
      check_val({tag, "_m_ctl"}, {29'd0, ifc.RegWriteM, ifc.MemWriteM, ifc.ResultSrcM},
                {29'd0, ifc.RegWriteE, ifc.MemWriteE, ifc.ResultSrcE});
      check_val({tag, "_m_rd"}, {27'd0, ifc.RD_M}, {27'd0, ifc.RD_E});
      check_val({tag, "_m_pc4"}, ifc.PCPlus4M, ifc.PCPlus4E);
      check_val({tag, "_m_wdata"}, ifc.WriteDataM, bf);
      check_val({tag, "_m_alu"}, ifc.ALU_ResultM, res);
      m_alu = res;
    end
  endtask

  task automatic check_m_zero(input string tag);
    check_val({tag, "_ctl"}, {29'd0, ifc.RegWriteM, ifc.MemWriteM, ifc.ResultSrcM}, 32'd0);
    check_val({tag, "_rd"}, {27'd0, ifc.RD_M}, 32'd0);
    check_val({tag, "_pc4"}, ifc.PCPlus4M, 32'd0);
    check_val({tag, "_wdata"}, ifc.WriteDataM, 32'd0);
    check_val({tag, "_alu"}, ifc.ALU_ResultM, 32'd0);
    check_val({tag, "_stall"}, {31'd0, ifc.StallE}, 32'd0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] rd1, rd2;
    logic [1:0]  fa, fb;
    logic        br, asrc;
    int          stall_cnt;

    n_checks = 0;
    n_errors = 0;
    m_alu    = 32'd0;
    rst      = 1'b1;
    ifc.RegWriteE = 0; ifc.MemWriteE = 0; ifc.ResultSrcE = 0; ifc.ALUSrcE = 0;
    ifc.BranchE = 0; ifc.FlushE = 0; ifc.ALUControlE = 3'd0;
    ifc.RD1_E = 0; ifc.RD2_E = 0; ifc.Imm_Ext_E = 0; ifc.PCE = 0; ifc.PCPlus4E = 0;
    ifc.ResultW = 0; ifc.RD_E = 0; ifc.ForwardA_E = 0; ifc.ForwardB_E = 0;

    #1;
    check_m_zero("reset_init");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Forwarding from the registered ALU result
    drive(1, 0, 0, 1, 0, 0, 3'd0, 32'd60, 32'd0, 32'd40, 32'h100, 32'd0, 5'd3, 2'b00, 2'b00);
    run_cycle("fwd_setup");
    drive(1, 0, 0, 1, 0, 0, 3'd0, 32'd5, 32'd9, 32'd7, 32'h104, 32'd0, 5'd4, 2'b10, 2'b00);
    run_cycle("fwd");
    check_val("fwd_add_107", ifc.ALU_ResultM, 32'd107);

    // Taken BEQ with a negative offset
    drive(0, 0, 0, 0, 1, 0, 3'd1, 32'h1234, 32'h1234, 32'hFFFF_FFF8, 32'h40, 32'd0, 5'd0,
          2'b00, 2'b00);
    #1;
    check_val("beq_taken", {31'd0, ifc.PCSrcE}, 32'd1);
    check_val("beq_target", ifc.PCTargetE, 32'h38);
    run_cycle("beq");

    // Flush kills a writing, branching instruction
    drive(1, 1, 1, 0, 1, 1, 3'd1, 32'h55, 32'h55, 32'h10, 32'h80, 32'd0, 5'd7, 2'b00, 2'b00);
    #1;
    check_val("flush_pcsrc", {31'd0, ifc.PCSrcE}, 32'd0);
    run_cycle("flush");
    check_val("flush_regwrite", {31'd0, ifc.RegWriteM}, 32'd0);
    check_val("flush_memwrite", {31'd0, ifc.MemWriteM}, 32'd0);
    check_val("flush_rd", {27'd0, ifc.RD_M}, 32'd0);

    // Signed/unsigned compare and wrap-around
    drive(1, 0, 0, 0, 0, 0, 3'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h90, 32'd0, 5'd1, 2'b00, 2'b00);
    run_cycle("slt");
    check_val("slt_neg1_lt_1", ifc.ALU_ResultM, 32'd1);
    drive(1, 0, 0, 0, 0, 0, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h94, 32'd0, 5'd1, 2'b00, 2'b00);
    run_cycle("sltu");
    check_val("sltu_max_lt_1", ifc.ALU_ResultM, 32'd0);
    drive(1, 0, 0, 0, 0, 0, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h98, 32'd0, 5'd1, 2'b00, 2'b00);
    run_cycle("add_wrap");
    check_val("add_wrap_zero", ifc.ALU_ResultM, 32'd0);

`ifndef EXEC_MUL_EN
    drive(1, 0, 0, 0, 0, 0, 3'd7, 32'd3, 32'd4, 32'd0, 32'h9C, 32'd0, 5'd2, 2'b00, 2'b00);
    run_cycle("op7_add");
    check_val("op7_is_add", ifc.ALU_ResultM, 32'd7);
`endif

    // Randomized instruction stream
    for (int i = 0; i < 200; i++) begin
`ifdef EXEC_MUL_EN
      op = 3'($urandom_range(0, 6));
`else
      op = 3'($urandom_range(0, 7));
`endif
      rd1  = $urandom;
      rd2  = $urandom;
      fa   = 2'($urandom_range(0, 3));
      fb   = 2'($urandom_range(0, 3));
      asrc = 1'($urandom_range(0, 1));
      br   = ($urandom_range(0, 3) == 0);
      if (br) begin
        op   = 3'd1;
        asrc = 1'b0;
        if ($urandom_range(0, 1) == 1) begin
          fa  = 2'b00;
          fb  = 2'b00;
          rd2 = rd1;
        end
      end
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            asrc, br, ($urandom_range(0, 7) == 0), op, rd1, rd2, $urandom, $urandom,
            $urandom, 5'($urandom_range(0, 31)), fa, fb);
      run_cycle("rand");
    end

    // Asynchronous reset mid-stream, with a MUL opcode present to test stall gating
    @(negedge clk);
    ifc.RegWriteE   = 1'b1;
    ifc.ALUControlE = 3'd7;
    rst = 1'b1;
    #1;
    check_m_zero("reset_mid");
    @(negedge clk);
    ifc.ALUControlE = 3'd0;
    ifc.FlushE      = 1'b1;
    rst   = 1'b0;
    m_alu = 32'd0;
    drive(1, 0, 0, 0, 0, 0, 3'd3, 32'hF0, 32'h0F, 32'd0, 32'h200, 32'd0, 5'd9, 2'b00, 2'b00);
    run_cycle("post_reset");
    check_val("post_reset_or", ifc.ALU_ResultM, 32'hFF);

`ifdef EXEC_MUL_EN
    drive(1, 0, 0, 0, 0, 0, 3'd7, 32'h0001_0000, 32'h0003_0003, 32'd0, 32'h300, 32'd0, 5'd5,
          2'b00, 2'b00);
    #1;
    stall_cnt = 0;
    for (int i = 0; i < 100 && ifc.StallE; i++) begin
      stall_cnt++;
      @(posedge clk);
      #1;
      check_val("mul_bubble", {31'd0, ifc.RegWriteM}, 32'd0);
    end
    check_val("mul_stall_len", stall_cnt, MUL_CYCLES + 1);
    @(posedge clk);
    #1;
    check_val("mul_result", ifc.ALU_ResultM, 32'h0001_0000 * 32'h0003_0003);
    check_val("mul_regwrite", {31'd0, ifc.RegWriteM}, 32'd1);
    check_val("mul_rd", {27'd0, ifc.RD_M}, 32'd5);
    m_alu = 32'h0003_0000;

    drive(1, 0, 0, 0, 0, 0, 3'd7, 32'h0001_0000, 32'h0003_0003, 32'd0, 32'h304, 32'd0, 5'd6,
          2'b00, 2'b00);
    repeat (10) @(posedge clk);
    drive(1, 0, 0, 0, 0, 1, 3'd0, 32'h0001_0000, 32'h0003_0003, 32'd0, 32'h304, 32'd0, 5'd6,
          2'b00, 2'b00);
    #1;
    check_val("mulflush_pcsrc", {31'd0, ifc.PCSrcE}, 32'd0);
    @(posedge clk);
    #1;
    check_val("mulflush_stall", {31'd0, ifc.StallE}, 32'd0);
    check_val("mulflush_regwrite", {31'd0, ifc.RegWriteM}, 32'd0);
    check_val("mulflush_alu", ifc.ALU_ResultM, 32'd0);
    m_alu = 32'd0;
    drive(1, 0, 0, 0, 0, 0, 3'd0, 32'h0001_0000, 32'h0003_0003, 32'd0, 32'h308, 32'd0, 5'd6,
          2'b00, 2'b00);
    run_cycle("post_mulflush");
    check_val("post_mulflush_add", ifc.ALU_ResultM, 32'h0004_0003);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
